// File: rtl/erosion_3x3_window.sv
// 3x3 grayscale erosion over a line-buffered pixel stream.
// Output is the window minimum, with frame syncs delayed to match the 4-clock pipeline.
module erosion_3x3_window #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W = 11,
  parameter logic [DATA_W-1:0] BORDER_VAL = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              per_frame_vsync,
  input  logic              per_frame_href,
  input  logic              per_frame_clken,
  input  logic [DATA_W-1:0] per_img_y,
  input  logic [DATA_W-1:0] taps0x,
  input  logic [DATA_W-1:0] taps1x,
  output logic              post_frame_vsync,
  output logic              post_frame_href,
  output logic              post_frame_clken,
  output logic [DATA_W-1:0] post_img_y
);

  localparam int unsigned SYNC_DEPTH = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] EDGE_IDX = CNT_W'(2);

  logic [DATA_W-1:0]           y_d1;
  logic [SYNC_DEPTH-1:0]       vsync_d;
  logic [SYNC_DEPTH-1:0]       href_d;
  logic [SYNC_DEPTH-1:0]       clken_d;
  logic [2:0][DATA_W-1:0]      win_top;
  logic [2:0][DATA_W-1:0]      win_mid;
  logic [2:0][DATA_W-1:0]      win_bot;
  logic [CNT_W-1:0]            col_idx;
  logic [CNT_W-1:0]            row_idx;
  logic                        win_ok_s1;
  logic                        win_ok_s2;
  logic [DATA_W-1:0]           r0;
  logic [DATA_W-1:0]           r1;
  logic [DATA_W-1:0]           r2;
  logic [DATA_W-1:0]           min_all_c;
  logic                        href_fall_c;

  function automatic logic [DATA_W-1:0] min2(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [DATA_W-1:0] min3(input logic [2:0][DATA_W-1:0] v);
    return min2(min2(v[0], v[1]), v[2]);
  endfunction

  // Stage 0: input pixel register and sync delay lines
  always_ff @(posedge clock) begin
    if (reset) begin
      y_d1    <= '0;
      vsync_d <= '0;
      href_d  <= '0;
      clken_d <= '0;
    end else begin
      y_d1    <= per_img_y;
      vsync_d <= {vsync_d[SYNC_DEPTH-2:0], per_frame_vsync};
      href_d  <= {href_d[SYNC_DEPTH-2:0], per_frame_href};
      clken_d <= {clken_d[SYNC_DEPTH-2:0], per_frame_clken};
    end
  end

  assign href_fall_c = href_d[1] & ~href_d[0];

  // Stage 1: window shift and position tracking; win_ok uses the pre-increment indices
  always_ff @(posedge clock) begin
    if (reset) begin
      col_idx   <= '0;
      row_idx   <= '0;
      win_top   <= '0;
      win_mid   <= '0;
      win_bot   <= '0;
      win_ok_s1 <= 1'b0;
    end else begin
      if (!href_d[0]) begin
        col_idx <= '0;
      end else if (clken_d[0] && (col_idx != CNT_MAX)) begin
        col_idx <= col_idx + CNT_W'(1);
      end

      if (vsync_d[0]) begin
        row_idx <= '0;
      end else if (href_fall_c && (row_idx != CNT_MAX)) begin
        row_idx <= row_idx + CNT_W'(1);
      end

      if (clken_d[0]) begin
        win_top   <= {win_top[1:0], taps1x};
        win_mid   <= {win_mid[1:0], taps0x};
        win_bot   <= {win_bot[1:0], y_d1};
        win_ok_s1 <= (col_idx >= EDGE_IDX) && (row_idx >= EDGE_IDX);
      end
    end
  end

  // Stage 2: per-row minima
  always_ff @(posedge clock) begin
    if (reset) begin
      r0        <= '0;
      r1        <= '0;
      r2        <= '0;
      win_ok_s2 <= 1'b0;
    end else begin
      r0        <= min3(win_top);
      r1        <= min3(win_mid);
      r2        <= min3(win_bot);
      win_ok_s2 <= win_ok_s1;
    end
  end

  assign min_all_c = min2(min2(r0, r1), r2);

  // Stage 3: final minimum or border fill
  always_ff @(posedge clock) begin
    if (reset) begin
      post_img_y <= '0;
    end else begin
      post_img_y <= win_ok_s2 ? min_all_c : BORDER_VAL;
    end
  end

  assign post_frame_vsync = vsync_d[SYNC_DEPTH-1];
  assign post_frame_href  = href_d[SYNC_DEPTH-1];
  assign post_frame_clken = clken_d[SYNC_DEPTH-1];

endmodule

// File: tb/tb_erosion_3x3_window.sv
// Bench for erosion_3x3_window: frame-level reference (image array + line-buffer queue)
// predicts every output pixel and the 4-clock delayed syncs.
module tb_erosion_3x3_window;

  logic       clock = 1'b0;
  logic       reset;
  logic       per_frame_vsync;
  logic       per_frame_href;
  logic       per_frame_clken;
  logic [7:0] per_img_y;
  logic [7:0] taps0x;
  logic [7:0] taps1x;
  logic       post_frame_vsync;
  logic       post_frame_href;
  logic       post_frame_clken;
  logic [7:0] post_img_y;

  always #5 clock = ~clock;

  erosion_3x3_window dut (
    .clock            (clock),
    .reset            (reset),
    .per_frame_vsync  (per_frame_vsync),
    .per_frame_href   (per_frame_href),
    .per_frame_clken  (per_frame_clken),
    .per_img_y        (per_img_y),
    .taps0x           (taps0x),
    .taps1x           (taps1x),
    .post_frame_vsync (post_frame_vsync),
    .post_frame_href  (post_frame_href),
    .post_frame_clken (post_frame_clken),
    .post_img_y       (post_img_y)
  );

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] img [0:15][0:15];
  logic [7:0] hist[$];
  logic [7:0] exp_q[$];
  logic [2:0] sync_q[$];
  logic [7:0] pend_t0 = 8'd0;
  logic [7:0] pend_t1 = 8'd0;
  int         line_w = 8;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Erosion of the frame image: output for input (r,c) is min over rows r-2..r, cols c-2..c
  function automatic logic [7:0] ref_pix(input int r, input int c);
    logic [7:0] m;
    if (r < 2 || c < 2) return 8'd0;
    m = 8'hFF;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        if (img[r-dr][c-dc] < m) m = img[r-dr][c-dc];
    return m;
  endfunction

  task automatic compare_outputs();
    logic [2:0] es;
    logic [7:0] ep;
    es = sync_q.pop_front();
    check("post_frame_vsync", 32'(post_frame_vsync), 32'(es[2]));
    check("post_frame_href",  32'(post_frame_href),  32'(es[1]));
    check("post_frame_clken", 32'(post_frame_clken), 32'(es[0]));
    if (es[0]) begin
      ep = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      check("post_img_y", 32'(post_img_y), 32'(ep));
    end
  endtask

  // One clock of stimulus; line-buffer taps for a pixel appear one clock after it
  task automatic tick(input logic vs, input logic hr, input logic ck,
                      input logic [7:0] pix, input int r, input int c);
    int n;
    reset           = 1'b0;
    per_frame_vsync = vs;
    per_frame_href  = hr;
    per_frame_clken = ck;
    per_img_y       = pix;
    taps0x          = pend_t0;
    taps1x          = pend_t1;
    if (ck) begin
      n = hist.size();
      pend_t0 = (n >= line_w)     ? hist[n-line_w]     : 8'd0;
      pend_t1 = (n >= 2 * line_w) ? hist[n-2*line_w]   : 8'd0;
      hist.push_back(pix);
      if (hist.size() > 64) void'(hist.pop_front());
      exp_q.push_back(ref_pix(r, c));
    end
    @(posedge clock);
    sync_q.push_back({vs, hr, ck});
    #1;
    compare_outputs();
  endtask

  task automatic pulse_reset();
    reset           = 1'b1;
    per_frame_vsync = 1'b0;
    per_frame_href  = 1'b0;
    per_frame_clken = 1'b0;
    per_img_y       = 8'($urandom);
    taps0x          = pend_t0;
    taps1x          = pend_t1;
    @(posedge clock);
    #1;
    check("rst_vsync", 32'(post_frame_vsync), 32'd0);
    check("rst_href",  32'(post_frame_href),  32'd0);
    check("rst_clken", 32'(post_frame_clken), 32'd0);
    check("rst_pix",   32'(post_img_y),       32'd0);
    reset = 1'b0;
    exp_q.delete();
    sync_q.delete();
    repeat (3) sync_q.push_back(3'b000);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 1'b0, 8'($urandom), 0, 0);
  endtask

  // gap_mode: 0 continuous, 1 alternate clken, 2 random gaps
  task automatic run_frame(input int w, input int h, input int gap_mode, input bit do_vsync);
    line_w = w;
    if (do_vsync) begin
      repeat (2) tick(1'b1, 1'b0, 1'b0, 8'd0, 0, 0);
      repeat (2) tick(1'b0, 1'b0, 1'b0, 8'd0, 0, 0);
    end
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if (gap_mode == 1 && c > 0)
          tick(1'b0, 1'b1, 1'b0, 8'($urandom), 0, 0);
        else if (gap_mode == 2)
          repeat ($urandom_range(0, 2)) tick(1'b0, 1'b1, 1'b0, 8'($urandom), 0, 0);
        tick(1'b0, 1'b1, 1'b1, img[r][c], r, c);
      end
      idle(3);
    end
  endtask

  task automatic drain(input string tag);
    idle(5);
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    per_frame_vsync = 1'b0;
    per_frame_href  = 1'b0;
    per_frame_clken = 1'b0;
    per_img_y = 8'd0;
    taps0x = 8'd0;
    taps1x = 8'd0;

    pulse_reset();
    pulse_reset();

    // Uniform 8x4 frame
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) img[r][c] = 8'd200;
    run_frame(8, 4, 0, 1'b1);
    drain("drain_uniform");

    // Single dark pixel, continuous then alternating clken
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) img[r][c] = 8'd250;
    img[3][3] = 8'd10;
    run_frame(8, 6, 0, 1'b1);
    drain("drain_dark");
    run_frame(8, 6, 1, 1'b1);
    drain("drain_dark_gapped");

    // Horizontal ramp
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) img[r][c] = 8'(c * 16);
    run_frame(8, 4, 0, 1'b1);
    drain("drain_ramp");

    // Back-to-back random frames with random gaps
    for (int f = 0; f < 3; f++) begin
      for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) img[r][c] = 8'($urandom);
      run_frame(10, 5, 2, 1'b1);
    end
    drain("drain_random");

    // Reset in the middle of a line, then continue without a new vsync
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) img[r][c] = 8'($urandom);
    line_w = 8;
    repeat (2) tick(1'b1, 1'b0, 1'b0, 8'd0, 0, 0);
    repeat (2) tick(1'b0, 1'b0, 1'b0, 8'd0, 0, 0);
    for (int c = 0; c < 8; c++) tick(1'b0, 1'b1, 1'b1, img[0][c], 0, c);
    idle(3);
    for (int c = 0; c < 4; c++) tick(1'b0, 1'b1, 1'b1, img[1][c], 1, c);
    pulse_reset();
    idle(2);
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) img[r][c] = 8'($urandom);
    run_frame(8, 4, 0, 1'b0);
    drain("drain_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
